uart_tx_fifo: RTL and testbench

UART transmitter with an internal write FIFO. It sits directly upstream of the UART receiver: it serialises DW-bit words into 8N1-style frames on TX, and each bit period matches the receiver's sampling interval (SLOOP_MAX+1 cycles). A producer writes words at clock rate, the FIFO absorbs bursts, and frames go out back-to-back with no idle gap while data remains.

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : 8N1-style UART transmitter fed by a circular write FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 10,
  parameter int BAUDRATE  = 9600,
  parameter int SLOOP_MAX = CLK_FREQ * 1000 * 1000 / BAUDRATE,
  parameter int DW        = 8,
  parameter int FIFO_AW   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DW-1:0]    din,
  input  logic             we,
  output logic             full,
  output logic [FIFO_AW:0] count,
  output logic             ovf,
  output logic             busy,
  output logic             TX
);

  localparam int c_DEPTH = 2 ** FIFO_AW;
  localparam int c_CW    = $clog2(SLOOP_MAX + 1);
  localparam int c_BW    = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [c_CW-1:0]    c_SLOOP    = c_CW'(SLOOP_MAX);
  localparam logic [c_BW-1:0]    c_BLAST    = c_BW'(DW - 1);
  localparam logic [FIFO_AW:0]   c_FULL_CNT = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
  logic [c_BW-1:0]     r_bidx, w_bidx_nxt;
  logic [DW-1:0]       r_shreg, w_shreg_nxt;
  logic                w_pop, w_wr, w_tx_nxt;
  logic [FIFO_AW-1:0]  r_wptr, r_rptr;
  logic [FIFO_AW:0]    r_count, w_count_nxt;
  logic                r_full, r_ovf, r_tx;
  logic [DW-1:0]       r_mem [c_DEPTH];

  // full is registered, so a write racing a pop on a full FIFO is dropped
  assign w_wr = we & ~r_full & ~RST;

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bidx_nxt  = r_bidx;
    w_shreg_nxt = r_shreg;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shreg_nxt = r_mem[r_rptr];
          w_cnt_nxt   = c_SLOOP;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = c_SLOOP;
          w_bidx_nxt  = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = c_SLOOP;
          w_shreg_nxt = r_shreg >> 1;
          if (r_bidx == c_BLAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bidx_nxt = r_bidx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          // Chain straight into the next start bit when data is waiting
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_shreg_nxt = r_mem[r_rptr];
            w_cnt_nxt   = c_SLOOP;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // TX is decoded from next-state values so the line register tracks state
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shreg_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shreg <= w_shreg_nxt;
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_ovf   <= r_ovf | (we & r_full);
      r_tx    <= w_tx_nxt;
    end
  end

  assign full  = r_full;
  assign count = r_count;
  assign ovf   = r_ovf;
  assign busy  = (r_state != S_IDLE) || (r_count != '0);
  assign TX    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Scoreboard bench; a line decoder checks TX frames against queued words.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int c_SM    = 15;
  localparam int c_BP    = c_SM + 1;
  localparam int c_DW    = 8;
  localparam int c_AW    = 4;
  localparam int c_FRAME = (c_DW + 2) * c_BP;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [7:0]      din = '0;
  logic            we  = 1'b0;
  logic            full;
  logic [c_AW:0]   count;
  logic            ovf;
  logic            busy;
  logic            TX;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_frames = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_busy    = 1'b0;
  bit         mon_discard = 1'b0;

  uart_tx_fifo #(
    .CLK_FREQ (10),
    .BAUDRATE (9600),
    .SLOOP_MAX(c_SM),
    .DW       (c_DW),
    .FIFO_AW  (c_AW)
  ) u_dut (
    .CLK  (CLK),
    .RST  (RST),
    .din  (din),
    .we   (we),
    .full (full),
    .count(count),
    .ovf  (ovf),
    .busy (busy),
    .TX   (TX)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit push);
    din = d;
    we  = 1'b1;
    if (push) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    i = 0;
    while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && i < max_cyc) begin
      tick(1);
      i++;
    end
    if (i >= max_cyc) check("drain_timeout", 0, 1);
  endtask

  // Called in cycle 0 with the write already presented; walks the whole frame.
  task automatic frame_check(input logic [7:0] b, input string tag);
    int   idx, ph;
    logic e;
    tick(1);
    we = 1'b0;
    check({tag, "_count_c1"}, 32'(count), 1);
    check({tag, "_busy_c1"}, 32'(busy), 1);
    for (int c = 2; c <= c_FRAME + 3; c++) begin
      tick(1);
      if (c == 2) check({tag, "_count_c2"}, 32'(count), 0);
      if (c <= c_FRAME + 1) begin
        idx = (c - 2) / c_BP;
        ph  = (c - 2) % c_BP;
        e   = (idx == 0) ? 1'b0 : (idx == c_DW + 1) ? 1'b1 : b[idx-1];
        if (ph == 0 || ph == c_BP - 1) check({tag, "_tx"}, 32'(TX), 32'(e));
      end
      if (c == c_FRAME + 1) check({tag, "_busy_stop"}, 32'(busy), 1);
      if (c == c_FRAME + 3) check({tag, "_busy_end"}, 32'(busy), 0);
    end
  endtask

  // Line decoder: samples each bit at its centre and pops the scoreboard.
  initial begin
    logic [7:0] b;
    logic       s0, s1;
    int         st;
    forever begin
      @(posedge CLK);
      #2;
      if (!RST && TX === 1'b0) begin
        mon_busy = 1'b1;
        st = cyc;
        repeat (c_BP / 2) @(posedge CLK);
        #2;
        s0 = TX;
        for (int k = 0; k < c_DW; k++) begin
          repeat (c_BP) @(posedge CLK);
          #2;
          b[k] = TX;
        end
        repeat (c_BP) @(posedge CLK);
        #2;
        s1 = TX;
        if (mon_discard) begin
          mon_discard = 1'b0;
        end else begin
          check("mon_start_bit", 32'(s0), 0);
          check("mon_stop_bit", 32'(s1), 1);
          if (exp_q.size() == 0) check("sb_unexpected_frame", 1, 0);
          else check("sb_data", 32'(b), 32'(exp_q.pop_front()));
          start_q.push_back(st);
          n_frames++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, t0;

    // Reset values
    tick(3);
    check("rst_tx", 32'(TX), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_busy", 32'(busy), 0);
    RST = 1'b0;
    tick(2);

    // Single word, cycle-exact frame
    wr(8'h55, 1'b1);
    frame_check(8'h55, "single");
    wait_idle(50);

    // Three-word burst, frames must abut
    start_q.delete();
    f0 = n_frames;
    t0 = cyc;
    wr(8'h00, 1'b1); tick(1);
    check("burst_count_c1", 32'(count), 1);
    wr(8'hFF, 1'b1); tick(1);
    check("burst_count_c2", 32'(count), 1);
    wr(8'hA3, 1'b1); tick(1);
    we = 1'b0;
    check("burst_count_c3", 32'(count), 2);
    wait_idle(4 * c_FRAME);
    check("burst_frames", 32'(n_frames - f0), 3);
    if (start_q.size() == 3) begin
      check("burst_first_start", 32'(start_q[0]), 32'(t0 + 2));
      check("burst_gap_1", 32'(start_q[1] - start_q[0]), c_FRAME);
      check("burst_gap_2", 32'(start_q[2] - start_q[1]), c_FRAME);
    end

    // Fill: 1 in flight + 16 queued, 18th write dropped, data wraps pointers
    f0 = n_frames;
    for (int i = 0; i < 17; i++) begin
      wr(8'(i), 1'b1);
      tick(1);
    end
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 16);
    check("fill_ovf_clear", 32'(ovf), 0);
    wr(8'hEE, 1'b0); tick(1);
    we = 1'b0;
    check("drop_ovf", 32'(ovf), 1);
    check("drop_full", 32'(full), 1);
    check("drop_count", 32'(count), 16);
    wait_idle(18 * c_FRAME);
    check("fill_frames", 32'(n_frames - f0), 17);
    check("ovf_sticky", 32'(ovf), 1);
    RST = 1'b1; tick(1);
    RST = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);
    tick(1);

    // Write coinciding with the STOP pop while full is dropped
    for (int i = 0; i < 17; i++) begin
      wr(8'h40 + 8'(i), 1'b1);
      tick(1);
    end
    we = 1'b0;
    tick(c_FRAME + 1 - 17);
    check("popw_pre_count", 32'(count), 16);
    check("popw_pre_full", 32'(full), 1);
    check("popw_pre_ovf", 32'(ovf), 0);
    wr(8'hEE, 1'b0); tick(1);
    we = 1'b0;
    check("popw_ovf", 32'(ovf), 1);
    check("popw_count", 32'(count), 15);
    check("popw_full", 32'(full), 0);
    check("popw_tx_start", 32'(TX), 0);
    wait_idle(17 * c_FRAME);
    RST = 1'b1; tick(1);
    RST = 1'b0;
    tick(1);

    // Reset mid DATA bit 3 truncates the frame and flushes the queue
    f0 = n_frames;
    wr(8'hA5, 1'b1); tick(1);
    wr(8'h5A, 1'b1); tick(1);
    we = 1'b0;
    tick(68);
    RST = 1'b1; tick(1);
    RST = 1'b0;
    if (mon_busy) mon_discard = 1'b1;
    exp_q.delete();
    check("midrst_tx", 32'(TX), 1);
    check("midrst_count", 32'(count), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_full", 32'(full), 0);
    check("midrst_ovf", 32'(ovf), 0);
    wait_idle(2 * c_FRAME);
    check("midrst_no_frame", 32'(n_frames - f0), 0);
    wr(8'h3C, 1'b1);
    frame_check(8'h3C, "postrst");
    wait_idle(50);
    check("postrst_frames", 32'(n_frames - f0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
